// File: rtl/rsa_seq_ctrl_pkg.sv
// Shared types and constants for the RSA sequencing controller.
package rsa_seq_pkg;

  localparam int          RSA_W        = 16;
  localparam int          RSA_PW       = 8;
  localparam logic [15:0] RSA_ERR_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    OP_KEYGEN = 2'b00,
    OP_ENC    = 2'b01,
    OP_DEC    = 2'b10,
    OP_RSVD   = 2'b11
  } rsa_op_e;

  typedef enum logic [3:0] {
    IDLE,
    PUB_GO,
    PUB_SETTLE,
    PUB_WAIT,
    PRIV_GO,
    PRIV_SETTLE,
    PRIV_WAIT,
    EXP_GO,
    EXP_SETTLE,
    EXP_WAIT,
    RESP
  } rsa_state_e;

endpackage

// File: rtl/rsa_seq_ctrl_if.sv
// Host command/response channel of the RSA sequencing controller.
interface rsa_seq_ctrl_if;
  import rsa_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [RSA_PW-1:0] cmd_p;
  logic [RSA_PW-1:0] cmd_q;
  logic [RSA_W-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RSA_W-1:0]  rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_p, cmd_q, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_p, cmd_q, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rsa_seq_ctrl_timer.sv
// Wait-state watchdog: up-counter reloaded to zero, saturating with a terminal flag
// after LIMIT counted cycles.
module rsa_seq_timer #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic term_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign term_o = (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !term_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// RSA sequencing controller: runs keygen / encrypt / decrypt on the datapath units.
// Optional watchdog on every WAIT state under `define RSA_SEQ_TIMEOUT_EN.
module rsa_seq_ctrl
  import rsa_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_seq_ctrl_if.slave     host,
  output logic              keys_valid,
  output logic [RSA_PW-1:0] key_e,
  output logic [RSA_W-1:0]  key_n,
  output logic [RSA_PW-1:0] dp_p,
  output logic [RSA_PW-1:0] dp_q,
  output logic              pub_start,
  input  logic              pub_finish,
  input  logic [RSA_PW-1:0] pub_e,
  output logic              priv_start,
  input  logic              priv_finish,
  input  logic [RSA_W-1:0]  priv_d,
  input  logic [RSA_W-1:0]  priv_n,
  output logic              mx_start,
  input  logic              mx_finish,
  input  logic [RSA_W-1:0]  mx_result,
  output logic [RSA_W-1:0]  mx_base,
  output logic [RSA_W-1:0]  mx_exp,
  output logic [RSA_W-1:0]  mx_mod
);

  rsa_state_e        state_q, state_d;
  rsa_op_e           op_q;
  logic              cmd_ready_q;
  logic              keys_valid_q;
  logic [RSA_PW-1:0] key_e_q, p_q, q_q;
  logic [RSA_W-1:0]  key_n_q, key_d_q, data_q, rsp_data_q;
  logic              rsp_err_q;
  logic              cmd_fire, is_keygen, accept_err, wait_tmo;

  assign cmd_fire   = host.cmd_valid && cmd_ready_q;
  assign is_keygen  = (host.cmd_op == OP_KEYGEN);
  // Operand checks use the live command so an error reaches RESP on the accept edge.
  assign accept_err = is_keygen
                    ? ((host.cmd_p < 8'd2) || (host.cmd_q < 8'd2))
                    : (!keys_valid_q || (host.cmd_data >= key_n_q) || (host.cmd_op == OP_RSVD));

`ifdef RSA_SEQ_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == PUB_WAIT) || (state_q == PRIV_WAIT) || (state_q == EXP_WAIT);

  rsa_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (!in_wait),
    .en_i   (in_wait),
    .term_o (wait_tmo)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wait_tmo           = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (cmd_fire) state_d = accept_err ? RESP : (is_keygen ? PUB_GO : EXP_GO);
      PUB_GO:      state_d = PUB_SETTLE;
      PUB_SETTLE:  state_d = PUB_WAIT;
      PUB_WAIT:    if (pub_finish) state_d = PRIV_GO;
                   else if (wait_tmo) state_d = RESP;
      PRIV_GO:     state_d = PRIV_SETTLE;
      PRIV_SETTLE: state_d = PRIV_WAIT;
      PRIV_WAIT:   if (priv_finish || wait_tmo) state_d = RESP;
      EXP_GO:      state_d = EXP_SETTLE;
      EXP_SETTLE:  state_d = EXP_WAIT;
      EXP_WAIT:    if (mx_finish || wait_tmo) state_d = RESP;
      RESP:        if (host.rsp_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_KEYGEN;
      p_q          <= '0;
      q_q          <= '0;
      data_q       <= '0;
      keys_valid_q <= 1'b0;
      key_e_q      <= '0;
      key_n_q      <= '0;
      key_d_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_fire) begin
          op_q      <= rsa_op_e'(host.cmd_op);
          p_q       <= host.cmd_p;
          q_q       <= host.cmd_q;
          data_q    <= host.cmd_data;
          rsp_err_q <= accept_err;
          if (accept_err) rsp_data_q <= RSA_ERR_WORD;
          // Keys are overwritten piecewise during keygen, so they are not valid meanwhile.
          if (is_keygen) keys_valid_q <= 1'b0;
        end
        PUB_WAIT: if (pub_finish) begin
          key_e_q <= pub_e;
        end else if (wait_tmo) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= RSA_ERR_WORD;
        end
        PRIV_WAIT: if (priv_finish) begin
          key_d_q      <= priv_d;
          key_n_q      <= priv_n;
          keys_valid_q <= 1'b1;
          rsp_data_q   <= priv_n;
        end else if (wait_tmo) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= RSA_ERR_WORD;
        end
        EXP_WAIT: if (mx_finish) begin
          rsp_data_q <= mx_result;
        end else if (wait_tmo) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= RSA_ERR_WORD;
        end
        default: ;
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = (state_q == RESP);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  assign keys_valid = keys_valid_q;
  assign key_e      = key_e_q;
  assign key_n      = key_n_q;
  assign dp_p       = p_q;
  assign dp_q       = q_q;
  assign pub_start  = (state_q == PUB_GO);
  assign priv_start = (state_q == PRIV_GO);
  assign mx_start   = (state_q == EXP_GO);
  assign mx_base    = data_q;
  assign mx_exp     = (op_q == OP_DEC) ? key_d_q : {8'h00, key_e_q};
  assign mx_mod     = key_n_q;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Directed bench for rsa_seq_ctrl with behavioural key-generator and mod-exp models.
module tb_rsa_seq_ctrl;
  import rsa_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rsa_seq_ctrl_if bus();

  logic        keys_valid, pub_start, priv_start, mx_start;
  logic [7:0]  key_e, dp_p, dp_q;
  logic [15:0] key_n, mx_base, mx_exp, mx_mod;
  logic        pub_finish  = 1'b1;
  logic        priv_finish = 1'b1;
  logic        mx_finish   = 1'b1;
  logic [7:0]  pub_e       = 8'h55;
  logic [15:0] priv_d      = 16'h1111;
  logic [15:0] priv_n      = 16'h2222;
  logic [15:0] mx_result   = 16'h1234;

  rsa_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .keys_valid(keys_valid), .key_e(key_e), .key_n(key_n), .dp_p(dp_p), .dp_q(dp_q),
    .pub_start(pub_start), .pub_finish(pub_finish), .pub_e(pub_e),
    .priv_start(priv_start), .priv_finish(priv_finish), .priv_d(priv_d), .priv_n(priv_n),
    .mx_start(mx_start), .mx_finish(mx_finish), .mx_result(mx_result),
    .mx_base(mx_base), .mx_exp(mx_exp), .mx_mod(mx_mod)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic int pick_e(input int phi);
    for (int e = 3; e < 256; e += 2) if (gcd(e, phi) == 1) return e;
    return 0;
  endfunction

  function automatic int mod_inv(input int e, input int phi);
    for (int d = 1; d < phi; d++) if ((e * d) % phi == 1) return d;
    return 0;
  endfunction

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                         input logic [15:0] m);
    logic [31:0] r, x;
    if (m == 0) return 16'h0;
    r = 1;
    x = 32'(b) % 32'(m);
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % 32'(m);
      x = (x * x) % 32'(m);
    end
    return r[15:0];
  endfunction

  // Datapath models: finish stays stale through GO and SETTLE, then drops, then rises after lat cycles.
  int pub_lat = 3, priv_lat = 2, mx_lat = 4;
  bit mx_hang = 1'b0;
  int pub_cnt = 0, priv_cnt = 0, mx_cnt = 0;
  logic [15:0] mx_next;
  int pub_pulses = 0, priv_pulses = 0, mx_pulses = 0;

  always @(negedge clk) begin
    int phi, e;
    phi = (int'(dp_p) - 1) * (int'(dp_q) - 1);
    e   = pick_e(phi);
    if (pub_start) begin
      pub_pulses++;
      pub_cnt = pub_lat + 1;
    end else if (pub_cnt > 0) begin
      pub_cnt--;
      if (pub_cnt != pub_lat) begin
        pub_finish = (pub_cnt == 0);
        if (pub_cnt == 0) pub_e = 8'(e);
      end
    end
    if (priv_start) begin
      priv_pulses++;
      priv_cnt = priv_lat + 1;
    end else if (priv_cnt > 0) begin
      priv_cnt--;
      if (priv_cnt != priv_lat) begin
        priv_finish = (priv_cnt == 0);
        if (priv_cnt == 0) begin
          priv_d = 16'(mod_inv(e, phi));
          priv_n = 16'(int'(dp_p) * int'(dp_q));
        end
      end
    end
    if (mx_start) begin
      mx_pulses++;
      mx_next = modexp(mx_base, mx_exp, mx_mod);
      mx_cnt  = mx_hang ? 0 : mx_lat + 1;
      if (mx_hang) mx_finish = 1'b0;
    end else if (mx_cnt > 0) begin
      mx_cnt--;
      if (mx_cnt != mx_lat) begin
        mx_finish = (mx_cnt == 0);
        if (mx_cnt == 0) mx_result = mx_next;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] p, input logic [7:0] q,
                       input logic [15:0] data);
    int guard = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_p     = p;
    bus.cmd_q     = q;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    do begin @(negedge clk); edges++; end while (!bus.rsp_valid && edges < 300);
    check("rsp_valid_within_bound", bus.rsp_valid, 1);
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  int edges, mx_before, pub_before, priv_before, guard;
  logic [15:0] held;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_p = '0; bus.cmd_q = '0;
    bus.cmd_data  = '0;   bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_keys", {keys_valid, key_e, key_n}, 0);
    check("rst_strobes", {pub_start, priv_start, mx_start}, 0);
    check("rst_operands", {dp_p, dp_q, mx_base, mx_exp}, 0);
    rst_n = 1'b1;
    #1 check("ready_low_before_first_edge", bus.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_first_edge", bus.cmd_ready, 1);

    // Encrypt with no keys: error on the first edge after accept, no mod-exp start.
    mx_before = mx_pulses;
    issue(OP_ENC, 8'd0, 8'd0, 16'd9);
    wait_rsp(edges);
    check("enc_nokey_latency", edges, 1);
    check("enc_nokey_err", bus.rsp_err, 1);
    check("enc_nokey_data", bus.rsp_data, 16'hDEAD);
    check("enc_nokey_no_mx_start", mx_pulses - mx_before, 0);
    ack_rsp();

    // Keygen with p<2.
    pub_before = pub_pulses;
    issue(OP_KEYGEN, 8'd1, 8'd13, 16'd0);
    wait_rsp(edges);
    check("keygen_bad_err", {bus.rsp_err, bus.rsp_data}, {1'b1, 16'hDEAD});
    check("keygen_bad_keys_valid", keys_valid, 0);
    check("keygen_bad_no_pub_start", pub_pulses - pub_before, 0);
    ack_rsp();

    // Keygen 11/13.
    pub_before = pub_pulses; priv_before = priv_pulses;
    issue(OP_KEYGEN, 8'd11, 8'd13, 16'd0);
    @(negedge clk);
    check("dp_p_held", dp_p, 11);
    check("dp_q_held", dp_q, 13);
    wait_rsp(edges);
    check("keygen_rsp", {bus.rsp_err, bus.rsp_data}, {1'b0, 16'd143});
    check("keygen_key_e", key_e, 7);
    check("keygen_key_n", key_n, 143);
    check("keygen_keys_valid", keys_valid, 1);
    check("keygen_one_pub_start", pub_pulses - pub_before, 1);
    check("keygen_one_priv_start", priv_pulses - priv_before, 1);
    ack_rsp();

    // Encrypt 9 -> 48, then hold the response for 10 cycles.
    mx_before = mx_pulses;
    issue(OP_ENC, 8'd0, 8'd0, 16'd9);
    wait_rsp(edges);
    check("enc_latency", edges, 3 + mx_lat);
    check("enc_rsp", {bus.rsp_err, bus.rsp_data}, {1'b0, 16'd48});
    check("enc_mx_exp", mx_exp, 7);
    check("enc_mx_base_mod", {mx_base, mx_mod}, {16'd9, 16'd143});
    check("enc_one_mx_start", mx_pulses - mx_before, 1);
    held = bus.rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_stable", {bus.rsp_valid, bus.rsp_data, bus.cmd_ready}, {1'b1, 16'd48, 1'b0});
    end

    // Release with a decrypt already pending: accepted one cycle after the handshake.
    mx_before = mx_pulses;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_DEC; bus.cmd_data = held;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("after_handshake_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_accepted", {mx_start, bus.cmd_ready}, 2'b10);
    wait_rsp(edges);
    check("dec_rsp", {bus.rsp_err, bus.rsp_data}, {1'b0, 16'd9});
    check("dec_mx_exp", mx_exp, 103);
    check("dec_one_mx_start", mx_pulses - mx_before, 1);
    ack_rsp();

    // Out-of-range data and reserved op.
    mx_before = mx_pulses;
    issue(OP_ENC, 8'd0, 8'd0, 16'd200);
    wait_rsp(edges);
    check("enc_range_rsp", {edges[7:0], bus.rsp_err, bus.rsp_data}, {8'd1, 1'b1, 16'hDEAD});
    ack_rsp();
    issue(OP_RSVD, 8'd0, 8'd0, 16'd5);
    wait_rsp(edges);
    check("rsvd_rsp", {bus.rsp_err, bus.rsp_data}, {1'b1, 16'hDEAD});
    check("err_no_mx_start", mx_pulses - mx_before, 0);
    ack_rsp();

`ifdef RSA_SEQ_TIMEOUT_EN
    mx_hang = 1'b1;
    issue(OP_ENC, 8'd0, 8'd0, 16'd9);
    wait_rsp(edges);
    check("timeout_latency", edges, 3 + 16);
    check("timeout_rsp", {bus.rsp_err, bus.rsp_data}, {1'b1, 16'hDEAD});
    ack_rsp();
    mx_hang = 1'b0;
`endif

    // Reset during PRIV_WAIT.
    priv_lat = 40;
    issue(OP_KEYGEN, 8'd11, 8'd13, 16'd0);
    guard = 0;
    while (!priv_start && guard < 100) begin @(negedge clk); guard++; end
    check("priv_start_seen", priv_start, 1);
    repeat (3) @(negedge clk);
    check("key_e_before_reset", key_e, 7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {bus.cmd_ready, bus.rsp_valid, pub_start, priv_start, mx_start}, 0);
    check("midrst_keys", {keys_valid, key_e, key_n}, 0);
    check("midrst_rsp", {bus.rsp_err, bus.rsp_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ENC, 8'd0, 8'd0, 16'd9);
    wait_rsp(edges);
    check("post_reset_enc_err", {bus.rsp_err, bus.rsp_data}, {1'b1, 16'hDEAD});
    ack_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
